// File: rtl/dco_sweep_pkg.sv
// Shared definitions for the DCO frequency-sweep controller: FSM state
// encoding and step-index width.
package dco_sweep_pkg;

    localparam int STEP_INDEX_W = 16;

    typedef logic [STEP_INDEX_W-1:0] step_idx_t;

    localparam step_idx_t STEP_INDEX_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_STEP   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter with clock enable and terminal-count flag; times
// both the settle and dwell phases of the sweep.
module sweep_timer #(
    parameter int TIMER_BITS = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  load,
    input  logic [TIMER_BITS-1:0] load_val,
    output logic                  tc
);

    logic [TIMER_BITS-1:0] cnt_q, cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (ce) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - TIMER_BITS'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/dco_sweep_ctrl.sv
// Steps a DCO phase increment from START_INC towards STOP_INC, settling and
// dwelling at each point. Optional DCO_SWEEP_CTRL_LOOP_EN adds a LOOP input.
module dco_sweep_ctrl
    import dco_sweep_pkg::*;
#(
    parameter int PHASE_INCREMENT_BITS = 28,
    parameter int TIMER_BITS           = 20,
    parameter int SETTLE_CYCLES        = 4
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic                            CE,
    input  logic                            START,
    input  logic                            ABORT,
`ifdef DCO_SWEEP_CTRL_LOOP_EN
    input  logic                            LOOP,
`endif
    input  logic [PHASE_INCREMENT_BITS-1:0] START_INC,
    input  logic [PHASE_INCREMENT_BITS-1:0] STOP_INC,
    input  logic [PHASE_INCREMENT_BITS-1:0] STEP_INC,
    input  logic [TIMER_BITS-1:0]           DWELL,
    output logic [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
    output logic                            PHASE_INCREMENT_WE,
    output logic                            MEASURE_VALID,
    output logic [STEP_INDEX_W-1:0]         STEP_INDEX,
    output logic                            BUSY,
    output logic                            DONE
);

    localparam int PB = PHASE_INCREMENT_BITS;
    localparam logic [TIMER_BITS-1:0] SETTLE_LOAD = TIMER_BITS'(SETTLE_CYCLES);

    sweep_state_e          state_q, state_d;
    logic [PB-1:0]         out_q, out_d;
    logic [PB-1:0]         start_s_q, start_s_d, stop_s_q, stop_s_d, step_s_q, step_s_d;
    logic [TIMER_BITS-1:0] dwell_s_q, dwell_s_d;
    logic                  we_q, we_d, done_q, done_d;
    step_idx_t             idx_q, idx_d;

    logic                  timer_load, timer_tc;
    logic [TIMER_BITS-1:0] timer_val, dwell_load;
    logic [PB:0]           next_sum;
    logic                  advance, loop_en;

`ifdef DCO_SWEEP_CTRL_LOOP_EN
    assign loop_en = LOOP;
`else
    assign loop_en = 1'b0;
`endif

    // The extra sum bit catches wrap-around so a sweep near full scale cannot alias to a small increment.
    assign next_sum   = {1'b0, out_q} + {1'b0, step_s_q};
    assign advance    = !next_sum[PB] && (next_sum[PB-1:0] <= stop_s_q) && (step_s_q != '0);
    assign dwell_load = (dwell_s_q == '0) ? '0 : dwell_s_q - TIMER_BITS'(1);

    sweep_timer #(.TIMER_BITS(TIMER_BITS)) u_timer (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .ce       (CE),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            start_s_q <= '0;
            stop_s_q  <= '0;
            step_s_q  <= '0;
            dwell_s_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            we_q      <= we_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            start_s_q <= start_s_d;
            stop_s_q  <= stop_s_d;
            step_s_q  <= step_s_d;
            dwell_s_q <= dwell_s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (CE) begin
            if (ABORT) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:   if (START) state_d = ST_SETTLE;
                    ST_SETTLE: if (timer_tc) state_d = ST_DWELL;
                    ST_DWELL:  if (timer_tc) state_d = ST_STEP;
                    ST_STEP:   state_d = (advance || loop_en) ? ST_SETTLE : ST_IDLE;
                    default:   state_d = ST_IDLE;
                endcase
            end
        end
    end

    // With CE low everything holds, so a strobe raised earlier waits for the next enabled cycle.
    always_comb begin
        out_d      = out_q;
        we_d       = we_q;
        done_d     = done_q;
        idx_d      = idx_q;
        start_s_d  = start_s_q;
        stop_s_d   = stop_s_q;
        step_s_d   = step_s_q;
        dwell_s_d  = dwell_s_q;
        timer_load = 1'b0;
        timer_val  = SETTLE_LOAD;
        if (CE) begin
            we_d   = 1'b0;
            done_d = 1'b0;
            if (ABORT) begin
                we_d  = 1'b1;
                out_d = '0;
                idx_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (START) begin
                            start_s_d  = START_INC;
                            stop_s_d   = STOP_INC;
                            step_s_d   = STEP_INC;
                            dwell_s_d  = DWELL;
                            we_d       = 1'b1;
                            out_d      = START_INC;
                            idx_d      = '0;
                            timer_load = 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer_tc) begin
                            timer_load = 1'b1;
                            timer_val  = dwell_load;
                        end
                    end
                    ST_STEP: begin
                        if (advance) begin
                            we_d       = 1'b1;
                            out_d      = next_sum[PB-1:0];
                            idx_d      = (idx_q == STEP_INDEX_MAX) ? idx_q : idx_q + step_idx_t'(1);
                            timer_load = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            if (loop_en) begin
                                we_d       = 1'b1;
                                out_d      = start_s_q;
                                idx_d      = '0;
                                timer_load = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        PHASE_INCREMENT_OUT = out_q;
        PHASE_INCREMENT_WE  = we_q & CE;
        MEASURE_VALID       = (state_q == ST_DWELL);
        STEP_INDEX          = idx_q;
        BUSY                = (state_q != ST_IDLE);
        DONE                = done_q & CE;
    end

endmodule

// File: tb/tb_dco_sweep_ctrl.sv
// Directed self-checking bench for dco_sweep_ctrl (SETTLE_CYCLES=4); the loop
// scenario is compiled only with DCO_SWEEP_CTRL_LOOP_EN.
module tb_dco_sweep_ctrl;

    localparam int P = 28;
    localparam int T = 20;

    logic          clk = 1'b0;
    logic          rst_n, ce, start, abort;
    logic [P-1:0]  start_inc, stop_inc, step_inc;
    logic [T-1:0]  dwell;
    logic [P-1:0]  out;
    logic          we, mv, busy, done;
    logic [15:0]   idx;
`ifdef DCO_SWEEP_CTRL_LOOP_EN
    logic          loop_i = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    logic [P-1:0]  wr_vals[$];
    logic [15:0]   wr_idx[$];
    int            mv_q[$];
    int            done_cnt, ce0_pulses, first_we, first_mv, done_cyc;
    bit            cap_timeout;

    dco_sweep_ctrl #(
        .PHASE_INCREMENT_BITS (P),
        .TIMER_BITS           (T),
        .SETTLE_CYCLES        (4)
    ) dut (
        .CLK                 (clk),
        .RESET_N             (rst_n),
        .CE                  (ce),
        .START               (start),
        .ABORT               (abort),
`ifdef DCO_SWEEP_CTRL_LOOP_EN
        .LOOP                (loop_i),
`endif
        .START_INC           (start_inc),
        .STOP_INC            (stop_inc),
        .STEP_INC            (step_inc),
        .DWELL               (dwell),
        .PHASE_INCREMENT_OUT (out),
        .PHASE_INCREMENT_WE  (we),
        .MEASURE_VALID       (mv),
        .STEP_INDEX          (idx),
        .BUSY                (busy),
        .DONE                (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at 1 time unit after the edge that sampled START: the write cycle.
    task automatic do_start(input logic [P-1:0] s, input logic [P-1:0] e,
                            input logic [P-1:0] st, input logic [T-1:0] dw);
        start_inc = s;
        stop_inc  = e;
        step_inc  = st;
        dwell     = dw;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic capture(input int max_cycles, input bit toggle);
        int  cyc;
        int  mv_cur;
        bit  got_done;
        wr_vals.delete(); wr_idx.delete(); mv_q.delete();
        done_cnt = 0; ce0_pulses = 0; first_we = -1; first_mv = -1; done_cyc = -1;
        cyc = 0; mv_cur = 0; got_done = 0;
        while (!got_done && cyc < max_cycles) begin
            ce = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (we) begin
                if (wr_vals.size() > 0) mv_q.push_back(mv_cur);
                mv_cur = 0;
                wr_vals.push_back(out);
                wr_idx.push_back(idx);
                if (first_we < 0) first_we = cyc;
            end
            if (mv && ce) begin
                mv_cur++;
                if (first_mv < 0) first_mv = cyc;
            end
            if (!ce && (we || done)) ce0_pulses++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                got_done = 1;
                mv_q.push_back(mv_cur);
            end
            if (!got_done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        cap_timeout = !got_done;
        ce = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; start = 1'b0; abort = 1'b0;
        start_inc = '0; stop_inc = '0; step_inc = '0; dwell = '0;
        #1;
        tests++;
        if ({out, we, mv, idx, busy, done} !== 48'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", {out, we, mv, idx, busy, done});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({we, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: got we/busy/done=%b expected 000", {we, busy, done});
        end
    endtask

    task automatic test_basic_sweep();
        logic [P-1:0] exp_v[4];
        logic [P-1:0] act;
        logic [15:0]  act_i;
        int           act_m;
        exp_v = '{28'd100, 28'd110, 28'd120, 28'd130};
        do_start(28'd100, 28'd130, 28'd10, 20'd3);
        capture(100, 1'b0);
        tests++;
        if (cap_timeout || wr_vals.size() != 4) begin
            fails++;
            $display("FAIL basic_write_count: got %0d timeout=%0d expected 4", wr_vals.size(), cap_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            act   = (i < wr_vals.size()) ? wr_vals[i] : 'x;
            act_i = (i < wr_idx.size())  ? wr_idx[i]  : 'x;
            act_m = (i < mv_q.size())    ? mv_q[i]    : -1;
            tests++;
            if (act !== exp_v[i]) begin
                fails++;
                $display("FAIL basic_write[%0d]: got %0d expected %0d", i, act, exp_v[i]);
            end
            tests++;
            if (act_i !== 16'(i)) begin
                fails++;
                $display("FAIL basic_step_index[%0d]: got %0d expected %0d", i, act_i, i);
            end
            tests++;
            if (act_m != 3) begin
                fails++;
                $display("FAIL basic_measure_cycles[%0d]: got %0d expected 3", i, act_m);
            end
        end
        // Write cycle + 4 settle cycles precede the first measure cycle.
        tests++;
        if (first_mv != 5) begin
            fails++;
            $display("FAIL basic_settle_len: first measure at %0d expected 5", first_mv);
        end
        // 9 cycles per point (write, 4 settle, 3 dwell, step); DONE follows the last step cycle.
        tests++;
        if (done_cyc != 36 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: cycle %0d busy %b expected 36 and 0", done_cyc, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out !== 28'd130 || we !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold_after_done: out %0d we %b done %b expected 130 0 0", out, we, done);
        end
    endtask

    task automatic test_bounds();
        logic [P-1:0] act;
        // No overshoot: 130 > 125 so the sweep stops after 120.
        do_start(28'd100, 28'd125, 28'd10, 20'd2);
        capture(100, 1'b0);
        act = (wr_vals.size() > 0) ? wr_vals[wr_vals.size()-1] : 'x;
        tests++;
        if (cap_timeout || wr_vals.size() != 3 || act !== 28'd120) begin
            fails++;
            $display("FAIL no_overshoot: %0d writes last %0d expected 3 writes last 120", wr_vals.size(), act);
        end
        // Zero step with zero dwell: one point, dwell floored to one cycle.
        do_start(28'd100, 28'd130, 28'd0, 20'd0);
        capture(100, 1'b0);
        act = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
        tests++;
        if (cap_timeout || wr_vals.size() != 1 || act !== 28'd100 || done_cnt != 1) begin
            fails++;
            $display("FAIL zero_step: %0d writes first %0d done %0d expected 1 100 1", wr_vals.size(), act, done_cnt);
        end
        tests++;
        if (mv_q.size() != 1 || mv_q[0] != 1) begin
            fails++;
            $display("FAIL zero_dwell: measure cycles %0d expected 1", (mv_q.size() > 0) ? mv_q[0] : -1);
        end
        // START_INC above STOP_INC: single point at START_INC.
        do_start(28'd200, 28'd150, 28'd10, 20'd1);
        capture(100, 1'b0);
        act = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
        tests++;
        if (cap_timeout || wr_vals.size() != 1 || act !== 28'd200) begin
            fails++;
            $display("FAIL start_above_stop: %0d writes first %0d expected 1 200", wr_vals.size(), act);
        end
    endtask

    task automatic test_carry();
        logic [P-1:0] a0, a1;
        do_start(28'hFFFFFF0, 28'hFFFFFFF, 28'd10, 20'd1);
        capture(100, 1'b0);
        a0 = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
        a1 = (wr_vals.size() > 1) ? wr_vals[1] : 'x;
        tests++;
        if (cap_timeout || wr_vals.size() != 2 || a0 !== 28'hFFFFFF0 || a1 !== 28'hFFFFFFA) begin
            fails++;
            $display("FAIL carry_stop: %0d writes %h %h expected 2 writes FFFFFF0 FFFFFFA", wr_vals.size(), a0, a1);
        end
    endtask

    task automatic test_abort();
        logic [P-1:0] exp_v[3];
        logic [P-1:0] act;
        int n;
        bit found;
        int late;
        exp_v = '{28'd100, 28'd110, 28'd120};
        wr_vals.delete();
        n = 0; found = 0;
        do_start(28'd100, 28'd130, 28'd10, 20'd3);
        while (!found && n < 200) begin
            if (we) wr_vals.push_back(out);
            if (idx == 16'd2 && mv) begin
                found = 1;
            end else begin
                if (n == 2) begin
                    start = 1'b1; start_inc = 28'd500; stop_inc = 28'd1000; step_inc = 28'd1;
                end
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
        end
        tests++;
        if (!found || wr_vals.size() != 3) begin
            fails++;
            $display("FAIL abort_reach_step2: found %0d writes %0d expected 1 3", found, wr_vals.size());
        end
        for (int i = 0; i < 3; i++) begin
            act = (i < wr_vals.size()) ? wr_vals[i] : 'x;
            tests++;
            if (act !== exp_v[i]) begin
                fails++;
                $display("FAIL start_ignored_write[%0d]: got %0d expected %0d", i, act, exp_v[i]);
            end
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests++;
        if ({we, out, idx, busy, done} !== {1'b1, 28'd0, 16'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL abort_response: we %b out %0d idx %0d busy %b done %b expected 1 0 0 0 0",
                     we, out, idx, busy, done);
        end
        late = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || we || busy) late++;
        end
        tests++;
        if (late != 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d active cycles after abort expected 0", late);
        end
    endtask

    task automatic test_ce_toggle();
        logic [P-1:0] exp_v[4];
        logic [P-1:0] act;
        int           act_m;
        exp_v = '{28'd100, 28'd110, 28'd120, 28'd130};
        do_start(28'd100, 28'd130, 28'd10, 20'd3);
        capture(200, 1'b1);
        tests++;
        if (cap_timeout || wr_vals.size() != 4 || done_cnt != 1) begin
            fails++;
            $display("FAIL ce_write_count: %0d writes done %0d expected 4 1", wr_vals.size(), done_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            act   = (i < wr_vals.size()) ? wr_vals[i] : 'x;
            act_m = (i < mv_q.size())    ? mv_q[i]    : -1;
            tests++;
            if (act !== exp_v[i] || act_m != 3) begin
                fails++;
                $display("FAIL ce_write[%0d]: got %0d/%0d measure expected %0d/3", i, act, act_m, exp_v[i]);
            end
        end
        tests++;
        if (ce0_pulses != 0) begin
            fails++;
            $display("FAIL ce_low_pulses: got %0d expected 0", ce0_pulses);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [P-1:0] act;
        int late;
        do_start(28'd100, 28'd130, 28'd10, 20'd3);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({out, we, mv, idx, busy, done} !== 48'h0) begin
            fails++;
            $display("FAIL reset_mid_settle: got %h expected 0", {out, we, mv, idx, busy, done});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        late = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (we || done || busy) late++;
        end
        tests++;
        if (late != 0) begin
            fails++;
            $display("FAIL reset_silent: %0d active cycles expected 0", late);
        end
        do_start(28'd40, 28'd60, 28'd10, 20'd1);
        capture(100, 1'b0);
        act = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
        tests++;
        if (cap_timeout || wr_vals.size() != 3 || act !== 28'd40 || wr_idx[0] !== 16'd0) begin
            fails++;
            $display("FAIL fresh_after_reset: %0d writes first %0d expected 3 writes first 40", wr_vals.size(), act);
        end
    endtask

`ifdef DCO_SWEEP_CTRL_LOOP_EN
    task automatic test_loop();
        logic [P-1:0] exp_v[9];
        logic [P-1:0] act;
        int dones;
        exp_v = '{28'd100, 28'd110, 28'd120, 28'd130, 28'd100, 28'd110, 28'd120, 28'd130, 28'd100};
        wr_vals.delete();
        dones = 0;
        loop_i = 1'b1;
        do_start(28'd100, 28'd130, 28'd10, 20'd3);
        for (int c = 0; c < 80; c++) begin
            if (we) wr_vals.push_back(out);
            if (done) dones++;
            @(posedge clk); #1;
        end
        tests++;
        if (wr_vals.size() != 9 || dones != 2) begin
            fails++;
            $display("FAIL loop_counts: %0d writes %0d done expected 9 2", wr_vals.size(), dones);
        end
        for (int i = 0; i < 9; i++) begin
            act = (i < wr_vals.size()) ? wr_vals[i] : 'x;
            tests++;
            if (act !== exp_v[i]) begin
                fails++;
                $display("FAIL loop_write[%0d]: got %0d expected %0d", i, act, exp_v[i]);
            end
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        loop_i = 1'b0;
        tests++;
        if ({we, out, busy, done} !== {1'b1, 28'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL loop_abort: we %b out %0d busy %b done %b expected 1 0 0 0", we, out, busy, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_sweep();
        test_bounds();
        test_carry();
        test_abort();
        test_ce_toggle();
        test_reset_mid_sweep();
`ifdef DCO_SWEEP_CTRL_LOOP_EN
        test_loop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
